hex_display_driver: RTL

//  Consumes the 32-bit out_command word of device_connection and shows it on a multiplexed 7-seg hex display.
//  - Time-multiplexes DIGITS digits, one nibble per digit.
//  - Captures value_in once per frame, so the display never shows a mix of two words.
//  - Sits directly downstream of device_connection on the board top level.

---
 rtl/hex_display_driver.sv | 119 +++++++++++
 1 files changed

// File: rtl/hex_display_driver.sv
// Multiplexed 7-segment hex display driver with a once-per-frame snapshot of value_in.
// Optional leading-zero blanking when HEXDISP_LZ_BLANK_EN is defined.
module hex_display_driver #(
  parameter int DIGITS      = 8,
  parameter int REFRESH_DIV = 50000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       value_in,
  input  logic              enable,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        seg,
  output logic              dp,
  output logic              frame_start
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int VW = 4 * DIGITS;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  logic [PW-1:0]     r_presc;
  logic [IW-1:0]     r_idx;
  logic [VW-1:0]     r_snap;
  logic              r_frame_start;
  logic [DIGITS-1:0] r_an;
  logic [6:0]        r_seg;

  logic              w_tick;
  logic              w_boundary;
  logic [3:0]        w_nib;
  logic [DIGITS-1:0] w_sel;
  logic [6:0]        w_font;
  logic              w_blank;

  assign w_tick     = (r_presc == PRESC_LAST);
  assign w_boundary = w_tick && (r_idx == IDX_LAST);

  always_comb begin
    w_nib = '0;
    w_sel = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == IW'(i)) begin
        w_nib    = r_snap[4*i +: 4];
        w_sel[i] = 1'b1;
      end
    end
  end

  // Active-high font, segments {g,f,e,d,c,b,a}
  always_comb begin
    w_font = 7'h00;
    case (w_nib)
      4'h0: w_font = 7'h3F;
      4'h1: w_font = 7'h06;
      4'h2: w_font = 7'h5B;
      4'h3: w_font = 7'h4F;
      4'h4: w_font = 7'h66;
      4'h5: w_font = 7'h6D;
      4'h6: w_font = 7'h7D;
      4'h7: w_font = 7'h07;
      4'h8: w_font = 7'h7F;
      4'h9: w_font = 7'h6F;
      4'hA: w_font = 7'h77;
      4'hB: w_font = 7'h7C;
      4'hC: w_font = 7'h39;
      4'hD: w_font = 7'h5E;
      4'hE: w_font = 7'h79;
      4'hF: w_font = 7'h71;
      default: w_font = 7'h00;
    endcase
  end

`ifdef HEXDISP_LZ_BLANK_EN
  logic [IW-1:0] w_hi;

  // Highest nonzero nibble; digit 0 is never blanked since w_hi >= 0
  always_comb begin
    w_hi = '0;
    for (int i = 1; i < DIGITS; i++) begin
      if (r_snap[4*i +: 4] != 4'h0) w_hi = IW'(i);
    end
  end

  assign w_blank = (r_idx > w_hi);
`else
  assign w_blank = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc       <= '0;
      r_idx         <= '0;
      r_snap        <= '0;
      r_frame_start <= 1'b0;
      r_an          <= '0;
      r_seg         <= '0;
    end else if (!enable) begin
      r_frame_start <= 1'b0;
      r_an          <= '0;
      r_seg         <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick) r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      if (w_boundary) r_snap <= value_in[VW-1:0];
      r_frame_start <= w_boundary;
      r_an          <= w_sel;
      r_seg         <= w_blank ? 7'h00 : w_font;
    end
  end

  assign an          = ACTIVE_LOW ? ~r_an : r_an;
  assign seg         = ACTIVE_LOW ? ~r_seg : r_seg;
  assign dp          = ACTIVE_LOW;
  assign frame_start = r_frame_start;

endmodule
